// File: rtl/wb_trace_tx.sv
// Writeback trace transmitter: buffers committed register writes in a small FIFO
// and streams them out with a valid/ready handshake. Define WB_TRACE_DROP_CNT_EN to add Drop_Count.
module wb_trace_tx #(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Cap_Valid,
   input  logic [31:0]      Cap_PC,
   input  logic [31:0]      Cap_Data,
   input  logic [4:0]       Cap_RegDst,
   output logic             Tx_Valid,
   input  logic             Tx_Ready,
   output logic [31:0]      Tx_PC,
   output logic [31:0]      Tx_Data,
   output logic [4:0]       Tx_RegDst,
   output logic [SEQ_W-1:0] Tx_Seq,
   output logic             Overflow
`ifdef WB_TRACE_DROP_CNT_EN
   ,
   output logic [15:0]      Drop_Count
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      data;
      logic [4:0]       reg_dst;
      logic [SEQ_W-1:0] seq;
   } rec_t;

   rec_t             rec_mem [DEPTH];
   rec_t             head_rec;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [SEQ_W-1:0] seq_cnt;
   logic             cap_event;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   assign cap_event = Cap_Valid && (Cap_RegDst != 5'd0);
   assign full      = (count == CNT_FULL);
   assign Tx_Valid  = (count != '0);
   assign pop       = Tx_Valid && Tx_Ready;
   // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
   assign push      = cap_event && (!full || pop);
   assign drop      = cap_event && full && !pop;

   always_ff @(posedge Clk) begin
      if (push) begin
         rec_mem[wr_ptr] <= '{pc: Cap_PC, data: Cap_Data, reg_dst: Cap_RegDst, seq: seq_cnt};
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         seq_cnt  <= '0;
         Overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
         // Sequence advances on drops too so the consumer sees gaps.
         if (cap_event) begin
            seq_cnt <= seq_cnt + 1'b1;
         end
         if (drop) begin
            Overflow <= 1'b1;
         end
      end
   end

`ifdef WB_TRACE_DROP_CNT_EN
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Drop_Count <= 16'd0;
      end else if (drop && (Drop_Count != 16'hFFFF)) begin
         Drop_Count <= Drop_Count + 16'd1;
      end
   end
`endif

   // Outputs forced to zero while empty so reset and idle values are defined.
   assign head_rec  = rec_mem[rd_ptr];
   assign Tx_PC     = Tx_Valid ? head_rec.pc      : 32'd0;
   assign Tx_Data   = Tx_Valid ? head_rec.data    : 32'd0;
   assign Tx_RegDst = Tx_Valid ? head_rec.reg_dst : 5'd0;
   assign Tx_Seq    = Tx_Valid ? head_rec.seq     : '0;

endmodule
